// File: rtl/list_record_writer_if.sv
// list_record_writer_if: element input handshake plus record write port.
//   in_vld/in_rdy/in_ptr/in_last : pointer list elements, one per handshake
//   out_we/out_wa/out_wd         : record write port toward the record memory
//   list_done/rec_count/err      : end-of-list pulse, record counter, sticky error
// modport master: list source / observer side; modport slave: the writer.
interface list_record_writer_if #(
  parameter int unsigned Width = 4,
  parameter int unsigned Lat   = 2
);
  logic                       in_vld;
  logic                       in_rdy;
  logic [Width-1:0]           in_ptr;
  logic                       in_last;
  logic                       out_we;
  logic [Width-1:0]           out_wa;
  logic [(Lat+1)*Width-1:0]   out_wd;
  logic                       list_done;
  logic [15:0]                rec_count;
  logic                       err;

  modport master (
    output in_vld, in_ptr, in_last,
    input  in_rdy, out_we, out_wa, out_wd, list_done, rec_count, err
  );

  modport slave (
    input  in_vld, in_ptr, in_last,
    output in_rdy, out_we, out_wa, out_wd, list_done, rec_count, err
  );
endinterface

// File: rtl/list_record_writer.sv
// list_record_writer: packs pointer lists into chained (Lat+1)-successor records.
//   clk, rst : clock, synchronous active-high reset
//   bus      : list_record_writer_if.slave (element input + record write port)
// A record keyed by a node holds its next Lat+1 successors; the last successor
// keys the following record and a list end is always closed by zero fill.
module list_record_writer #(
  parameter int unsigned n     = 16,
  parameter int unsigned Width = $clog2(n),
  parameter int unsigned Lat   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  list_record_writer_if.slave  bus
);
  localparam int unsigned Slots = Lat + 1;
  localparam int unsigned RecW  = Slots * Width;
  localparam int unsigned KW    = (Lat > 0) ? $clog2(Lat + 1) : 1;

  typedef enum logic [1:0] {HEAD, BODY, FLUSH} state_t;

  state_t            r_state;
  logic [Width-1:0]  r_key;
  logic [RecW-1:0]   r_slots;
  logic [KW-1:0]     r_k;
  logic              r_we;
  logic [Width-1:0]  r_wa;
  logic [RecW-1:0]   r_wd;
  logic              r_done;
  logic [15:0]       r_cnt;
  logic              r_err;

  logic              w_acc;
  logic              w_null;
  logic              w_k_full;
  logic [RecW-1:0]   w_rec;

  assign bus.in_rdy = (r_state != FLUSH);
  assign w_acc      = bus.in_vld && (r_state != FLUSH);
  assign w_null     = (bus.in_ptr == '0);
  assign w_k_full   = (r_k == KW'(Lat));

  // Current slots with the incoming element placed at slot k; slots above k
  // are kept zero by clearing at every record start.
  always_comb begin
    w_rec = r_slots;
    for (int unsigned i = 0; i < Slots; i++) begin
      if (r_k == KW'(i)) w_rec[i*Width +: Width] = bus.in_ptr;
    end
  end

  // Record assembly FSM with registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HEAD;
      r_key   <= '0;
      r_slots <= '0;
      r_k     <= '0;
      r_we    <= 1'b0;
      r_wa    <= '0;
      r_wd    <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        HEAD: begin
          if (w_acc) begin
            if (w_null) begin
              r_err <= 1'b1;
            end else begin
              r_key   <= bus.in_ptr;
              r_k     <= '0;
              r_slots <= '0;
              if (bus.in_last) begin
                // single-node list: zero record keyed by the node itself
                r_we   <= 1'b1;
                r_wa   <= bus.in_ptr;
                r_wd   <= '0;
                r_done <= 1'b1;
                r_cnt  <= r_cnt + 16'd1;
              end else begin
                r_state <= BODY;
              end
            end
          end
        end
        BODY: begin
          if (w_acc) begin
            if (w_null) begin
              r_err <= 1'b1;
            end else if (!w_k_full) begin
              if (bus.in_last) begin
                r_we    <= 1'b1;
                r_wa    <= r_key;
                r_wd    <= w_rec;
                r_done  <= 1'b1;
                r_cnt   <= r_cnt + 16'd1;
                r_slots <= '0;
                r_k     <= '0;
                r_state <= HEAD;
              end else begin
                r_slots <= w_rec;
                r_k     <= r_k + KW'(1);
              end
            end else begin
              // record full: the element just taken keys the next record
              r_we    <= 1'b1;
              r_wa    <= r_key;
              r_wd    <= w_rec;
              r_cnt   <= r_cnt + 16'd1;
              r_key   <= bus.in_ptr;
              r_k     <= '0;
              r_slots <= '0;
              r_state <= bus.in_last ? FLUSH : BODY;
            end
          end
        end
        FLUSH: begin
          // terminating zero record for a list ending on a record key
          r_we    <= 1'b1;
          r_wa    <= r_key;
          r_wd    <= '0;
          r_done  <= 1'b1;
          r_cnt   <= r_cnt + 16'd1;
          r_state <= HEAD;
        end
        default: r_state <= HEAD;
      endcase
    end
  end

  assign bus.out_we    = r_we;
  assign bus.out_wa    = r_wa;
  assign bus.out_wd    = r_wd;
  assign bus.list_done = r_done;
  assign bus.rec_count = r_cnt;
  assign bus.err       = r_err;
endmodule
